// File: rtl/turbo_rx_checker_if.sv
// +--------------------------------------------------------------------+
// | turbo_rx_checker_if : beat input, byte output and status bundle     |
// | Revision 1.0                                                        |
// +--------------------------------------------------------------------+
`default_nettype none

interface turbo_rx_checker_if;
  logic        start;
  logic [12:0] k_len;
  logic        data_valid;
  logic        xk1;
  logic        zk1;
  logic        xk2;
  logic        zk2;
  logic        in_ready;
  logic [7:0]  dout;
  logic        dout_valid;
  logic        dout_ready;
  logic [12:0] par1_err_cnt;
  logic [12:0] par2_err_cnt;
  logic        tail_err;
  logic        done;

  modport master (
    output start, k_len, data_valid, xk1, zk1, xk2, zk2, dout_ready,
    input  in_ready, dout, dout_valid, par1_err_cnt, par2_err_cnt, tail_err, done
  );

  modport slave (
    input  start, k_len, data_valid, xk1, zk1, xk2, zk2, dout_ready,
    output in_ready, dout, dout_valid, par1_err_cnt, par2_err_cnt, tail_err, done
  );
endinterface

`default_nettype wire

// File: rtl/turbo_rx_checker.sv
// +--------------------------------------------------------------------+
// | turbo_rx_checker : re-encodes a received turbo block, counts parity |
// | mismatches, checks trellis termination and packs systematic bits.   |
// | Revision 1.0                                                        |
// +--------------------------------------------------------------------+
`default_nettype none

module turbo_rx_checker (
  input  logic                  clk,
  input  logic                  aclr,
  turbo_rx_checker_if.slave     bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DATA  = 2'd1,
    ST_TAIL  = 2'd2,
    ST_FLUSH = 2'd3
  } state_t;

  localparam logic [12:0] CNT_MAX = 13'h1FFF;

  state_t      state_q,      state_d;
  logic [12:0] k_last_q,     k_last_d;
  logic [12:0] beat_cnt_q,   beat_cnt_d;
  logic [1:0]  tail_cnt_q,   tail_cnt_d;
  logic [2:0]  enc1_q,       enc1_d;
  logic [2:0]  enc2_q,       enc2_d;
  logic [6:0]  pack_q,       pack_d;
  logic [2:0]  pack_cnt_q,   pack_cnt_d;
  logic [7:0]  dout_q,       dout_d;
  logic        dout_valid_q, dout_valid_d;
  logic [12:0] par1_q,       par1_d;
  logic [12:0] par2_q,       par2_d;
  logic        tail_err_q,   tail_err_d;
  logic        done_q,       done_d;

  logic        w_out_free;
  logic        w_in_ready;
  logic        w_fire;
  logic [3:0]  w_step1;
  logic [3:0]  w_step2;
  logic        w_tail_u1;
  logic        w_tail_z1;
  logic        w_tail_u2;
  logic        w_tail_z2;
  logic [7:0]  w_partial;

  // State bit 0 is s1, bit 2 is s3; returns {z, next_state}.
  function automatic logic [3:0] rsc_step(input logic [2:0] st, input logic u);
    logic a;
    logic z;
    a = u ^ st[1] ^ st[2];
    z = a ^ st[0] ^ st[2];
    return {z, st[1], st[0], a};
  endfunction

  assign w_step1   = rsc_step(enc1_q, bus.xk1);
  assign w_step2   = rsc_step(enc2_q, bus.xk2);
  assign w_tail_u1 = enc1_q[1] ^ enc1_q[2];
  assign w_tail_z1 = enc1_q[0] ^ enc1_q[2];
  assign w_tail_u2 = enc2_q[1] ^ enc2_q[2];
  assign w_tail_z2 = enc2_q[0] ^ enc2_q[2];

  // Bits enter at the top of pack_q, so a partial byte is right-aligned by shifting.
  assign w_partial  = {1'b0, pack_q} >> (3'd7 - pack_cnt_q);
  assign w_out_free = !dout_valid_q || bus.dout_ready;

  always_comb begin
    w_in_ready = 1'b0;
    case (state_q)
      ST_DATA: w_in_ready = !((pack_cnt_q == 3'd7) && !w_out_free);
      ST_TAIL: w_in_ready = 1'b1;
      default: w_in_ready = 1'b0;
    endcase
  end

  assign w_fire = bus.data_valid && w_in_ready;

  always_comb begin
    state_d      = state_q;
    k_last_d     = k_last_q;
    beat_cnt_d   = beat_cnt_q;
    tail_cnt_d   = tail_cnt_q;
    enc1_d       = enc1_q;
    enc2_d       = enc2_q;
    pack_d       = pack_q;
    pack_cnt_d   = pack_cnt_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    par1_d       = par1_q;
    par2_d       = par2_q;
    tail_err_d   = tail_err_q;
    done_d       = 1'b0;

    if (dout_valid_q && bus.dout_ready) begin
      dout_valid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d    = ST_DATA;
          k_last_d   = bus.k_len - 13'd1;
          beat_cnt_d = 13'd0;
          tail_cnt_d = 2'd0;
          enc1_d     = 3'd0;
          enc2_d     = 3'd0;
          pack_d     = 7'd0;
          pack_cnt_d = 3'd0;
          par1_d     = 13'd0;
          par2_d     = 13'd0;
          tail_err_d = 1'b0;
        end
      end

      ST_DATA: begin
        if (w_fire) begin
          enc1_d = w_step1[2:0];
          enc2_d = w_step2[2:0];
          if ((bus.zk1 != w_step1[3]) && (par1_q != CNT_MAX)) begin
            par1_d = par1_q + 13'd1;
          end
          if ((bus.zk2 != w_step2[3]) && (par2_q != CNT_MAX)) begin
            par2_d = par2_q + 13'd1;
          end
          if (pack_cnt_q == 3'd7) begin
            dout_d       = {bus.xk1, pack_q};
            dout_valid_d = 1'b1;
            pack_d       = 7'd0;
            pack_cnt_d   = 3'd0;
          end else begin
            pack_d     = {bus.xk1, pack_q[6:1]};
            pack_cnt_d = pack_cnt_q + 3'd1;
          end
          if (beat_cnt_q == k_last_q) begin
            state_d    = ST_TAIL;
            beat_cnt_d = 13'd0;
          end else begin
            beat_cnt_d = beat_cnt_q + 13'd1;
          end
        end
      end

      ST_TAIL: begin
        if (w_fire) begin
          // The models follow the received tail so a bad tail leaves a non-zero state.
          enc1_d = w_step1[2:0];
          enc2_d = w_step2[2:0];
          if ((bus.xk1 != w_tail_u1) || (bus.zk1 != w_tail_z1) ||
              (bus.xk2 != w_tail_u2) || (bus.zk2 != w_tail_z2)) begin
            tail_err_d = 1'b1;
          end
          if (tail_cnt_q == 2'd2) begin
            state_d = ST_FLUSH;
            if ((w_step1[2:0] != 3'd0) || (w_step2[2:0] != 3'd0)) begin
              tail_err_d = 1'b1;
            end
            if ((pack_cnt_q != 3'd0) && w_out_free) begin
              dout_d       = w_partial;
              dout_valid_d = 1'b1;
              pack_d       = 7'd0;
              pack_cnt_d   = 3'd0;
            end
          end else begin
            tail_cnt_d = tail_cnt_q + 2'd1;
          end
        end
      end

      ST_FLUSH: begin
        if (w_out_free) begin
          if (pack_cnt_q != 3'd0) begin
            dout_d       = w_partial;
            dout_valid_d = 1'b1;
            pack_d       = 7'd0;
            pack_cnt_d   = 3'd0;
          end else begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (aclr) begin
      state_q      <= ST_IDLE;
      k_last_q     <= 13'd0;
      beat_cnt_q   <= 13'd0;
      tail_cnt_q   <= 2'd0;
      enc1_q       <= 3'd0;
      enc2_q       <= 3'd0;
      pack_q       <= 7'd0;
      pack_cnt_q   <= 3'd0;
      dout_q       <= 8'd0;
      dout_valid_q <= 1'b0;
      par1_q       <= 13'd0;
      par2_q       <= 13'd0;
      tail_err_q   <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      k_last_q     <= k_last_d;
      beat_cnt_q   <= beat_cnt_d;
      tail_cnt_q   <= tail_cnt_d;
      enc1_q       <= enc1_d;
      enc2_q       <= enc2_d;
      pack_q       <= pack_d;
      pack_cnt_q   <= pack_cnt_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      par1_q       <= par1_d;
      par2_q       <= par2_d;
      tail_err_q   <= tail_err_d;
      done_q       <= done_d;
    end
  end

  assign bus.in_ready     = w_in_ready;
  assign bus.dout         = dout_q;
  assign bus.dout_valid   = dout_valid_q;
  assign bus.par1_err_cnt = par1_q;
  assign bus.par2_err_cnt = par2_q;
  assign bus.tail_err     = tail_err_q;
  assign bus.done         = done_q;

endmodule

`default_nettype wire

// File: tb/tb_turbo_rx_checker.sv
// +--------------------------------------------------------------------+
// | tb_turbo_rx_checker : directed scenarios with a byte scoreboard     |
// | Revision 1.0                                                        |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_turbo_rx_checker;

  logic clk = 1'b0;
  logic aclr;

  always #5 clk = ~clk;

  turbo_rx_checker_if bus ();

  turbo_rx_checker dut (
    .clk  (clk),
    .aclr (aclr),
    .bus  (bus)
  );

  int tests = 0;
  int fails = 0;
  logic [7:0] exp_q[$];
  int done_cnt = 0;
  int stall_seen = 0;
  int stall_idx = 0;

  bit x1_arr[6144];
  bit x2_arr[6144];
  bit inv1[6144];
  bit inv2[6144];
  int tail_flip = -1;
  int ghost_at  = -1;
  int abort_at  = -1;
  bit gaps      = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic bm_step(inout bit s1, inout bit s2, inout bit s3, input bit u, output bit z);
    bit a;
    a  = u ^ s2 ^ s3;
    z  = a ^ s1 ^ s3;
    s3 = s2;
    s2 = s1;
    s1 = a;
  endtask

  task automatic clear_setup();
    for (int i = 0; i < 6144; i++) begin
      x1_arr[i] = 1'b0;
      x2_arr[i] = 1'b0;
      inv1[i]   = 1'b0;
      inv2[i]   = 1'b0;
    end
    tail_flip = -1;
    ghost_at  = -1;
    abort_at  = -1;
    gaps      = 1'b0;
  endtask

  // Byte scoreboard and done-pulse counter.
  always @(negedge clk) begin
    if (bus.done) done_cnt++;
    if (!aclr && bus.dout_valid && bus.dout_ready) begin
      if (exp_q.size() == 0) chk("sb_extra_byte", 32'(exp_q.size()), 32'd1);
      else chk("dout_byte", {24'd0, bus.dout}, {24'd0, exp_q.pop_front()});
    end
  end

  task automatic beat(input int idx);
    int n;
    n = 0;
    bus.data_valid = 1'b1;
    @(negedge clk);
    while (!bus.in_ready && n < 200) begin
      if (stall_seen == 0) begin
        stall_seen = 1;
        stall_idx  = idx;
      end
      n++;
      @(negedge clk);
    end
    if (n >= 200) chk("beat_timeout", n, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic run_block(input int k, input int exp_p1, input int exp_p2, input bit exp_tail);
    bit m1s1, m1s2, m1s3, m2s1, m2s2, m2s3;
    bit u1, u2, z1, z2;
    logic [7:0] acc;
    int nb;
    int n;
    done_cnt   = 0;
    stall_seen = 0;
    m1s1 = 0; m1s2 = 0; m1s3 = 0;
    m2s1 = 0; m2s2 = 0; m2s3 = 0;
    acc = 8'd0;
    nb  = 0;
    bus.data_valid = 1'b0;
    bus.start      = 1'b1;
    bus.k_len      = 13'(k);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.k_len = 13'($urandom_range(40, 6144));
    for (int i = 0; i < k; i++) begin
      if (i == abort_at) return;
      if (gaps && $urandom_range(0, 3) == 0) begin
        bus.data_valid = 1'b0;
        bus.xk1 = 1'($urandom); bus.zk1 = 1'($urandom);
        bus.xk2 = 1'($urandom); bus.zk2 = 1'($urandom);
        @(posedge clk);
        #1;
      end
      u1 = x1_arr[i];
      u2 = x2_arr[i];
      bm_step(m1s1, m1s2, m1s3, u1, z1);
      bm_step(m2s1, m2s2, m2s3, u2, z2);
      bus.xk1 = u1;
      bus.zk1 = z1 ^ inv1[i];
      bus.xk2 = u2;
      bus.zk2 = z2 ^ inv2[i];
      if (i == ghost_at) begin
        bus.start = 1'b1;
        bus.k_len = 13'd100;
      end
      beat(i);
      bus.start = 1'b0;
      acc[nb] = u1;
      nb++;
      if (nb == 8) begin
        exp_q.push_back(acc);
        acc = 8'd0;
        nb  = 0;
      end
    end
    for (int t = 0; t < 3; t++) begin
      u1 = m1s2 ^ m1s3;
      u2 = m2s2 ^ m2s3;
      bm_step(m1s1, m1s2, m1s3, u1, z1);
      bm_step(m2s1, m2s2, m2s3, u2, z2);
      bus.xk1 = u1 ^ (t == tail_flip);
      bus.zk1 = z1;
      bus.xk2 = u2;
      bus.zk2 = z2;
      beat(k + t);
    end
    bus.data_valid = 1'b0;
    if (nb > 0) exp_q.push_back(acc);
    n = 0;
    while (done_cnt == 0 && n < 1000) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("done_seen", done_cnt, 1);
    chk("par1_err_cnt", {19'd0, bus.par1_err_cnt}, exp_p1);
    chk("par2_err_cnt", {19'd0, bus.par2_err_cnt}, exp_p2);
    chk("tail_err", {31'd0, bus.tail_err}, {31'd0, exp_tail});
    chk("bytes_pending_at_done", 32'(exp_q.size()), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("done_single_pulse", done_cnt, 1);
    chk("par1_hold", {19'd0, bus.par1_err_cnt}, exp_p1);
    chk("tail_err_hold", {31'd0, bus.tail_err}, {31'd0, exp_tail});
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_dout"},       {24'd0, bus.dout}, 32'd0);
    chk({tag, "_dout_valid"}, {31'd0, bus.dout_valid}, 32'd0);
    chk({tag, "_in_ready"},   {31'd0, bus.in_ready}, 32'd0);
    chk({tag, "_done"},       {31'd0, bus.done}, 32'd0);
    chk({tag, "_tail_err"},   {31'd0, bus.tail_err}, 32'd0);
    chk({tag, "_par1"},       {19'd0, bus.par1_err_cnt}, 32'd0);
    chk({tag, "_par2"},       {19'd0, bus.par2_err_cnt}, 32'd0);
  endtask

  initial begin
    int n;
    bus.start      = 1'b0;
    bus.k_len      = 13'd0;
    bus.data_valid = 1'b0;
    bus.xk1 = 1'b0; bus.zk1 = 1'b0; bus.xk2 = 1'b0; bus.zk2 = 1'b0;
    bus.dout_ready = 1'b1;
    aclr = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    aclr = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk);
    #1;

    // All-zero block.
    clear_setup();
    run_block(40, 0, 0, 1'b0);

    // Impulse on beat 0 of both encoders.
    clear_setup();
    x1_arr[0] = 1'b1;
    x2_arr[0] = 1'b1;
    run_block(40, 0, 0, 1'b0);

    // Injected parity errors, idle gaps, and a stray start mid-block.
    clear_setup();
    inv1[5]  = 1'b1;
    inv1[17] = 1'b1;
    inv2[39] = 1'b1;
    ghost_at = 10;
    gaps     = 1'b1;
    run_block(40, 2, 1, 1'b0);

    // Random K=44 with output back-pressure after the first byte.
    clear_setup();
    for (int i = 0; i < 44; i++) begin
      x1_arr[i] = 1'($urandom);
      x2_arr[i] = 1'($urandom);
    end
    fork
      run_block(44, 0, 0, 1'b0);
      begin
        n = 0;
        @(negedge clk);
        while (!bus.dout_valid && n < 500) begin
          n++;
          @(negedge clk);
        end
        @(posedge clk);
        #1;
        bus.dout_ready = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        bus.dout_ready = 1'b1;
      end
    join
    chk("stall_seen", stall_seen, 1);
    chk("stall_at_packer_full", stall_idx % 8, 7);

    // Bad tail bit on the second tail beat.
    clear_setup();
    tail_flip = 1;
    run_block(40, 0, 0, 1'b1);

    // Reset in the middle of a long block, colliding with start and a beat.
    clear_setup();
    for (int i = 0; i < 64; i++) x1_arr[i] = 1'($urandom);
    abort_at = 20;
    run_block(6144, 0, 0, 1'b0);
    bus.data_valid = 1'b1;
    bus.start      = 1'b1;
    bus.k_len      = 13'd40;
    aclr           = 1'b1;
    @(posedge clk);
    #1;
    aclr           = 1'b0;
    bus.start      = 1'b0;
    bus.data_valid = 1'b0;
    @(negedge clk);
    check_reset_outputs("midblock_reset");
    chk("midblock_reset_no_pending", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
    clear_setup();
    run_block(40, 0, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire

// File: doc/turbo_rx_checker.md
TURBO_RX_CHECKER -- requirements
Module: turbo_rx_checker

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; every register updates on its rising edge.
REQ-002 SHALL have port aclr, input, 1 bit: synchronous, active-high reset, sampled on the rising edge of clk.
REQ-003 SHALL have port start, input, 1 bit: one-cycle pulse that begins a block; honoured only in IDLE.
REQ-004 SHALL have port k_len, input, 13 bits: block length K in bits, legal range 40..6144, sampled on start.
REQ-005 SHALL have port data_valid, input, 1 bit: marks the current beat {xk1, zk1, xk2, zk2} as valid.
REQ-006 SHALL have ports xk1, zk1, xk2, zk2, input, 1 bit each: systematic and parity bits of constituent encoders 1 and 2.
REQ-007 SHALL have port in_ready, output, 1 bit: the block accepts a beat only when data_valid && in_ready.
REQ-008 SHALL have port dout, output, 8 bits: recovered systematic xk1 bits packed into a byte.
REQ-009 SHALL have ports dout_valid, output, 1 bit, and dout_ready, input, 1 bit: a byte transfers when both are high.
REQ-010 SHALL have ports par1_err_cnt and par2_err_cnt, output, 13 bits each: parity-mismatch counts for encoders 1 and 2.
REQ-011 SHALL have ports tail_err, output, 1 bit, and done, output, 1 bit: tail-check result and a one-cycle end-of-block pulse.

Function
REQ-012 SHALL implement the states IDLE -> DATA (K beats) -> TAIL (3 beats) -> FLUSH -> IDLE.
REQ-013 IDLE SHALL move to DATA on start; on that edge it SHALL latch k_len and clear both counters, tail_err, the packer and both local encoder states.
REQ-014 in_ready SHALL be 0 in IDLE and FLUSH.
REQ-015 SHALL contain two local RSC models, each with 3-bit state s1..s3, feedback a = u^s2^s3, parity z = a^s1^s3, and shift (s1,s2,s3) <= (a,s1,s2).
REQ-016 On each accepted DATA beat, model 1 SHALL use u = xk1 and model 2 SHALL use u = xk2.
REQ-017 On each accepted DATA beat, if zk1 differs from model 1's z, par1_err_cnt SHALL increment; par2_err_cnt SHALL behave the same way for zk2 against model 2.
REQ-018 Both error counters SHALL saturate at 8191.
REQ-019 On each TAIL beat, the expected input SHALL be u = s2^s3, so that a = 0.
REQ-020 tail_err SHALL set (sticky until start) when xk1 != expected u, zk1 != expected z, xk2 != expected u, or zk2 != expected z on a TAIL beat.
REQ-021 tail_err SHALL also set when either model state is non-zero after the third TAIL beat.
REQ-022 The packer SHALL take xk1 from DATA beats only, LSB first: the first bit of a block lands in dout[0].
REQ-023 When 8 bits are packed, the packer SHALL load them into the output register, which sets dout_valid.
REQ-024 If K mod 8 != 0, the final partial byte SHALL be zero-padded in the upper bits and loaded on entry to FLUSH.
REQ-025 The output register SHALL hold a single byte: dout_valid clears on transfer, unless a new byte loads in the same cycle.
REQ-026 in_ready SHALL be 0 in DATA while 7 bits are packed and dout_valid && !dout_ready, so no bit is ever lost or overwritten.
REQ-027 FLUSH SHALL wait until the output register is empty or transferring, then pulse done for one cycle and return to IDLE.
REQ-028 Counters and tail_err SHALL hold their values from done until the next start.
REQ-029 A start pulse outside IDLE SHALL be ignored.
REQ-030 Beats with data_valid=0 SHALL not advance any state.
REQ-031 Beat counting SHALL use a 13-bit counter compared with the latched K-1; a change on k_len mid-block SHALL have no effect.

Reset
REQ-032 When aclr=1 at a rising edge of clk, the next state SHALL be IDLE, regardless of the current state, with partial block data discarded.
REQ-033 After that edge: dout=0, dout_valid=0, in_ready=0, done=0, tail_err=0, par1_err_cnt=0, par2_err_cnt=0.
REQ-034 After that edge, both model states and the packer SHALL be 0.
REQ-035 aclr SHALL take priority over start and over any handshake in the same cycle.

Verification
REQ-036 K=40, all four inputs 0 for 40 DATA and 3 TAIL beats, dout_ready=1 -> five bytes 0x00, both counters 0, tail_err=0, one done pulse.
REQ-037 K=40, xk1=xk2 impulse on beat 0 with reference-model parity and tail -> zk1 beats 0..3 expected as 1,1,1,1, dout bytes 0x01,0x00,0x00,0x00,0x00, counters 0, tail_err=0.
REQ-038 Scenario REQ-036 with zk1 inverted on beats 5 and 17 and zk2 inverted on beat 39 -> par1_err_cnt=2, par2_err_cnt=1, tail_err=0.
REQ-039 K=44 random data, dout_ready=0 for 20 cycles after the first byte -> in_ready drops at the packer-full point, no beat is lost, bytes match the input, and the sixth byte carries 4 data bits with upper nibble 0.
REQ-040 Scenario REQ-036 with xk1=1 on the second TAIL beat -> tail_err=1 and done still pulses.
REQ-041 aclr asserted at DATA beat 20 of K=6144, then a fresh K=40 block -> all outputs are reset values, and the new block completes exactly as in REQ-036.
